// File: rtl/cpstr_unesc.sv
// Control-port stream unescaper.
// Splits one escaped receive byte stream into a main data stream (ESC ESC
// collapsed back to a single ESC) and an escape/command stream (the byte that
// follows a lone ESC). Each output stream has one output register, giving
// 1-cycle latency and full throughput per stream.
module cpstr_unesc #(
    parameter logic [7:0] ESC_CHAR = 8'd27
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic [7:0] o_esc_data,
    output logic       o_esc_valid,
    input  logic       i_esc_ready,
    output logic       o_esc_pend
);

    typedef enum logic {
        ST_NORMAL  = 1'b0,
        ST_ESCAPED = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        TGT_NONE = 2'd0,
        TGT_MAIN = 2'd1,
        TGT_ESC  = 2'd2
    } target_t;

    state_t     state_q, state_d;
    logic       main_valid_q, main_valid_d;
    logic [7:0] main_data_q, main_data_d;
    logic       esc_valid_q, esc_valid_d;
    logic [7:0] esc_data_q, esc_data_d;

    logic       is_esc;
    logic       main_can_load;
    logic       esc_can_load;
    logic       accept;
    target_t    target;

    assign is_esc        = (i_data == ESC_CHAR);
    assign main_can_load = !main_valid_q || i_ready;
    assign esc_can_load  = !esc_valid_q || i_esc_ready;

    // Decide which output slot the current input byte is destined for, and
    // only stall the input when that particular slot cannot take it.
    always_comb begin
        target  = TGT_MAIN;
        o_ready = 1'b0;
        if (state_q == ST_NORMAL) begin
            target = is_esc ? TGT_NONE : TGT_MAIN;
        end else begin
            target = is_esc ? TGT_MAIN : TGT_ESC;
        end
        case (target)
            TGT_NONE: o_ready = 1'b1;
            TGT_MAIN: o_ready = main_can_load;
            TGT_ESC:  o_ready = esc_can_load;
            default:  o_ready = 1'b0;
        endcase
    end

    assign accept = i_valid && o_ready;

    // Next-state for the decoder state and both output slots; a load in the
    // same cycle as a transfer keeps the slot valid (back-to-back).
    always_comb begin
        state_d      = state_q;
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        esc_valid_d  = esc_valid_q;
        esc_data_d   = esc_data_q;

        if (main_valid_q && i_ready) begin
            main_valid_d = 1'b0;
        end
        if (esc_valid_q && i_esc_ready) begin
            esc_valid_d = 1'b0;
        end

        if (accept) begin
            case (target)
                TGT_MAIN: begin
                    main_valid_d = 1'b1;
                    main_data_d  = i_data;
                end
                TGT_ESC: begin
                    esc_valid_d = 1'b1;
                    esc_data_d  = i_data;
                end
                default: ;
            endcase
            // A lone ESC arms the escape; any byte in ESCAPED completes it.
            if (state_q == ST_NORMAL) begin
                state_d = is_esc ? ST_ESCAPED : ST_NORMAL;
            end else begin
                state_d = ST_NORMAL;
            end
        end
    end

    // State and output registers; reset drops any pending escape and both slots.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_NORMAL;
            main_valid_q <= 1'b0;
            main_data_q  <= 8'd0;
            esc_valid_q  <= 1'b0;
            esc_data_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            esc_valid_q  <= esc_valid_d;
            esc_data_q   <= esc_data_d;
        end
    end

    assign o_valid     = main_valid_q;
    assign o_data      = main_data_q;
    assign o_esc_valid = esc_valid_q;
    assign o_esc_data  = esc_data_q;
    assign o_esc_pend  = (state_q == ST_ESCAPED);

endmodule

// File: tb/tb_cpstr_unesc.sv
// Testbench for cpstr_unesc: directed scenarios followed by a randomized run,
// all checked every cycle against a queue-based reference of the unescaping rules.
module tb_cpstr_unesc;

    localparam logic [7:0] ESC = 8'h1B;
    localparam int NRAND = 1500;

    logic       i_clk;
    logic       i_rst;
    logic [7:0] i_data;
    logic       i_valid;
    logic       o_ready;
    logic [7:0] o_data;
    logic       o_valid;
    logic       i_ready;
    logic [7:0] o_esc_data;
    logic       o_esc_valid;
    logic       i_esc_ready;
    logic       o_esc_pend;

    cpstr_unesc #(.ESC_CHAR(8'd27)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_data      (i_data),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_esc_data  (o_esc_data),
        .o_esc_valid (o_esc_valid),
        .i_esc_ready (i_esc_ready),
        .o_esc_pend  (o_esc_pend)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int errors = 0;
    int checks = 0;

    // Reference: bytes decoded but not yet taken by each sink, plus escape flag.
    logic [7:0] qm[$];
    logic [7:0] qe[$];
    bit         m_esc;
    bit         acc;
    logic [7:0] rbytes[NRAND];

    task automatic chk1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Apply the unescaping rules to one accepted input byte.
    task automatic model_decode(input logic [7:0] b);
        if (!m_esc) begin
            if (b == ESC) m_esc = 1'b1;
            else qm.push_back(b);
        end else begin
            m_esc = 1'b0;
            if (b == ESC) qm.push_back(ESC);
            else qe.push_back(b);
        end
    endtask

    // One clock: check outputs at the negedge, advance the model, return at posedge+1.
    task automatic tick();
        logic exp_rdy;
        logic to_esc;
        @(negedge i_clk);
        acc = 1'b0;
        if (i_rst) begin
            qm.delete();
            qe.delete();
            m_esc = 1'b0;
        end else begin
            chk1("main_valid", o_valid, qm.size() != 0);
            if (qm.size() != 0) chk8("main_data", o_data, qm[0]);
            chk1("esc_valid", o_esc_valid, qe.size() != 0);
            if (qe.size() != 0) chk8("esc_data", o_esc_data, qe[0]);
            chk1("esc_pend", o_esc_pend, m_esc);
            to_esc = m_esc && (i_data != ESC);
            if (!m_esc && i_data == ESC) exp_rdy = 1'b1;
            else if (to_esc) exp_rdy = (qe.size() == 0) || i_esc_ready;
            else exp_rdy = (qm.size() == 0) || i_ready;
            if (i_valid) chk1("ready", o_ready, exp_rdy);
            acc = i_valid && exp_rdy;
            if (qm.size() != 0 && i_ready) void'(qm.pop_front());
            if (qe.size() != 0 && i_esc_ready) void'(qe.pop_front());
            if (acc) model_decode(i_data);
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        i_valid = 1'b1;
        i_data  = b;
        do begin
            tick();
            n++;
        end while (!acc && n < 200);
        checks++;
        assert (acc === 1'b1) else begin
            errors++;
            $error("FAIL send_timeout: byte %h not accepted after %0d cycles", b, n);
        end
        i_valid = 1'b0;
    endtask

    initial begin
        int idx;
        int cyc;
        i_rst       = 1'b1;
        i_valid     = 1'b0;
        i_data      = 8'h00;
        i_ready     = 1'b1;
        i_esc_ready = 1'b1;
        m_esc       = 1'b0;
        acc         = 1'b0;
        tick();
        tick();
        i_rst = 1'b0;

        // Reset state
        chk1("rst_valid", o_valid, 1'b0);
        chk8("rst_data", o_data, 8'h00);
        chk1("rst_esc_valid", o_esc_valid, 1'b0);
        chk8("rst_esc_data", o_esc_data, 8'h00);
        chk1("rst_pend", o_esc_pend, 1'b0);

        // Plain bytes, back to back
        send(8'h41);
        send(8'h42);
        send(8'h43);
        tick();
        tick();

        // Doubled ESC collapses to one main byte
        send(ESC);
        chk1("t2_pend", o_esc_pend, 1'b1);
        send(ESC);
        tick();
        tick();

        // Escape command then main byte
        send(ESC);
        send(8'h05);
        chk1("t3_esc_valid", o_esc_valid, 1'b1);
        chk8("t3_esc_data", o_esc_data, 8'h05);
        send(8'h41);
        tick();
        tick();

        // Stalled escape sink blocks only escape-targeted bytes
        i_esc_ready = 1'b0;
        send(ESC);
        send(8'h07);
        send(8'h41);
        send(ESC);
        i_valid = 1'b1;
        i_data  = 8'h09;
        repeat (3) tick();
        chk1("t4_stall_ready", o_ready, 1'b0);
        chk8("t4_esc_held", o_esc_data, 8'h07);
        chk1("t4_main_drained", o_valid, 1'b0);
        i_esc_ready = 1'b1;
        send(8'h09);
        tick();
        tick();

        // Stalled main sink holds its byte; release gives a back-to-back transfer
        i_ready = 1'b0;
        send(8'h20);
        i_valid = 1'b1;
        i_data  = 8'h30;
        repeat (3) tick();
        chk1("t5_stall_ready", o_ready, 1'b0);
        chk8("t5_data_held", o_data, 8'h20);
        i_ready = 1'b1;
        send(8'h30);
        chk1("t5_b2b_valid", o_valid, 1'b1);
        chk8("t5_b2b_data", o_data, 8'h30);
        tick();
        tick();

        // Reset discards a pending escape
        send(ESC);
        chk1("t6_pend_set", o_esc_pend, 1'b1);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        chk1("t6_pend_clr", o_esc_pend, 1'b0);
        send(8'h05);
        chk1("t6_main_valid", o_valid, 1'b1);
        chk8("t6_main_data", o_data, 8'h05);
        chk1("t6_no_esc", o_esc_valid, 1'b0);
        tick();

        // Randomized run with ESC-heavy data and random handshakes
        for (int i = 0; i < NRAND; i++) begin
            if ($urandom_range(0, 2) == 0) rbytes[i] = ESC;
            else rbytes[i] = 8'($urandom);
        end
        idx = 0;
        cyc = 0;
        while (idx < NRAND && cyc < 30000) begin
            i_valid     = ($urandom_range(0, 3) != 0);
            i_data      = rbytes[idx];
            i_ready     = ($urandom_range(0, 3) != 0);
            i_esc_ready = ($urandom_range(0, 3) != 0);
            tick();
            if (acc) idx++;
            cyc++;
        end
        checks++;
        assert (idx === NRAND) else begin
            errors++;
            $error("FAIL rand_timeout: accepted %0d required %0d", idx, NRAND);
        end
        i_valid     = 1'b0;
        i_ready     = 1'b1;
        i_esc_ready = 1'b1;
        repeat (4) tick();
        chk1("drain_main", o_valid, 1'b0);
        chk1("drain_esc", o_esc_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
